// File: rtl/reg_wb_queue_pkg.sv
// Shared definitions for the register-file writeback queue.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-index widths
//   NUM_REGS                : registers in the file (8x16)
//   wb_entry_t              : one queued writeback {register index, data}
package reg_wb_queue_pkg;

    localparam int NUM_REGS   = 8;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = $clog2(NUM_REGS);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] idx;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_fifo.sv
// In-order storage for pending register writes.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   push         : write push_entry at tail, tail advances
//   pop          : head advances
//   ovr          : overwrite the youngest entry (tail-1) with ovr_entry
//   entries      : contents ordered by age, entries[0] is the head (oldest)
//   entry_vld    : entry_vld[i] set when entries[i] holds a queued write
//   count        : number of queued entries
// push and ovr are never asserted together by the parent.
module wb_queue_fifo
    import reg_wb_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    input  logic                   ovr,
    input  entry_t                 ovr_entry,
    output entry_t                 entries [DEPTH],
    output logic [DEPTH-1:0]       entry_vld,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   cnt;

    // Pointers are exactly log2(DEPTH) bits, so increments wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Contents need no reset: nothing is visible unless covered by count.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
        if (ovr)  mem[tail - PW'(1)] <= ovr_entry;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i]   = mem[head + PW'(i)];
            entry_vld[i] = (CW'(i) < cnt);
        end
    end

    assign count = cnt;

endmodule

// File: rtl/reg_wb_queue.sv
// Write-side front end for the 8x16 register file.
// Buffers writeback requests in an in-order queue and drains at most one per
// cycle onto a registered register-file write port. A combinational lookup
// exposes writes that are queued or sitting in the output stage so readers
// can forward them before the register file commits (at negedge).
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wb_valid/wb_ready          : writeback handshake; wb_reg/wb_data payload
//   rf_hold                    : inhibits draining while high
//   rf_wr_en/rf_write_reg/
//   rf_write_data              : registered register-file write port
//   q_reg -> q_hit/q_data      : pending-write lookup (youngest match wins)
//   count                      : number of queued entries
//
// Handshake: a request transfers at a posedge where wb_valid && wb_ready are
// both high; wb_ready does not depend on a pop in the same cycle, so there is
// no pass-through from input to output stage.
//
// Build option WB_COALESCE_EN: a push to the same register as the youngest
// queued entry overwrites that entry in place (even when full), unless that
// entry is the head being popped in the same cycle.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [ADDR_W-1:0]      wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   rf_hold,
    output logic                   rf_wr_en,
    output logic [ADDR_W-1:0]      rf_write_reg,
    output logic [DATA_W-1:0]      rf_write_data,
    input  logic [ADDR_W-1:0]      q_reg,
    output logic                   q_hit,
    output logic [DATA_W-1:0]      q_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] entry_vld;
    entry_t           in_entry;
    logic             full;
    logic             pop;
    logic             enq;
    logic             ovr;

    assign in_entry = '{idx: wb_reg, data: wb_data};
    assign full     = (count == CW'(DEPTH));
    assign pop      = (count != '0) && !rf_hold;

`ifdef WB_COALESCE_EN
    logic [CW-1:0] young_pos;
    logic          coalescible;

    assign young_pos   = count - CW'(1);
    // With a single entry the youngest is also the head; if it leaves this
    // cycle the new value must be enqueued rather than lost.
    assign coalescible = (count != '0)
                         && (entries[young_pos[CW-2:0]].idx == wb_reg)
                         && !(pop && count == CW'(1));
    assign wb_ready    = !full || (wb_valid && coalescible);
    assign ovr         = wb_valid && wb_ready && coalescible;
    assign enq         = wb_valid && wb_ready && !coalescible;
`else
    assign wb_ready    = !full;
    assign ovr         = 1'b0;
    assign enq         = wb_valid && wb_ready;
`endif

    wb_queue_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (enq),
        .push_entry (in_entry),
        .pop        (pop),
        .ovr        (ovr),
        .ovr_entry  (in_entry),
        .entries    (entries),
        .entry_vld  (entry_vld),
        .count      (count)
    );

    // Output stage: idle cycles keep the last index/data, only rf_wr_en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (pop) begin
            rf_wr_en      <= 1'b1;
            rf_write_reg  <= entries[0].idx;
            rf_write_data <= entries[0].data;
        end else begin
            rf_wr_en      <= 1'b0;
        end
    end

    // Lookup: the output stage is older than anything queued, so it is
    // considered first and then overridden by queue entries oldest->youngest.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (rf_wr_en && rf_write_reg == q_reg) begin
            q_hit  = 1'b1;
            q_data = rf_write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && entries[i].idx == q_reg) begin
                q_hit  = 1'b1;
                q_data = entries[i].data;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [2:0]  wb_reg = '0;
  logic [15:0] wb_data = '0;
  logic        rf_hold = 1'b0;
  logic        rf_wr_en;
  logic [2:0]  rf_write_reg;
  logic [15:0] rf_write_data;
  logic [2:0]  q_reg = '0;
  logic        q_hit;
  logic [15:0] q_data;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  reg_wb_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .rf_hold       (rf_hold),
    .rf_wr_en      (rf_wr_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .q_reg         (q_reg),
    .q_hit         (q_hit),
    .q_data        (q_data),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [15:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
  endtask

  task automatic push(input logic [2:0] r, input logic [15:0] d);
    drive(r, d);
    step();
    wb_valid = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [2:0] r, input logic [15:0] d);
    check({tag, "_en"}, 32'(rf_wr_en), 32'd1);
    check({tag, "_reg"}, 32'(rf_write_reg), 32'(r));
    check({tag, "_data"}, 32'(rf_write_data), 32'(d));
  endtask

  task automatic lookup(input string tag, input logic [2:0] r, input logic hit, input logic [15:0] d);
    q_reg = r;
    #1;
    check({tag, "_hit"}, 32'(q_hit), 32'(hit));
    check({tag, "_data"}, 32'(q_data), 32'(d));
  endtask

  initial begin
    // reset state
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_ready", 32'(wb_ready), 32'd1);
    check("rst_reg", 32'(rf_write_reg), 32'd0);
    check("rst_data", 32'(rf_write_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single push: write appears one cycle after acceptance
    push(3'd3, 16'h00AB);
    check("t1_count_q", 32'(count), 32'd1);
    check("t1_wr_idle", 32'(rf_wr_en), 32'd0);
    step();
    expect_wr("t1_wr", 3'd3, 16'h00AB);
    check("t1_count_0", 32'(count), 32'd0);
    step();
    check("t1_wr_off", 32'(rf_wr_en), 32'd0);
    check("t1_hold_data", 32'(rf_write_data), 32'h00AB);

    // fill under hold, stall a 5th request, then drain in order
    rf_hold = 1'b1;
    push(3'd1, 16'h1001);
    push(3'd2, 16'h2002);
    push(3'd4, 16'h4004);
    push(3'd6, 16'h6006);
    check("t2_full_count", 32'(count), 32'd4);
    check("t2_full_ready", 32'(wb_ready), 32'd0);
    lookup("t2_look4", 3'd4, 1'b1, 16'h4004);
    lookup("t2_look7", 3'd7, 1'b0, 16'h0000);
    drive(3'd7, 16'h7777);
    #1;
    check("t2_stall_ready", 32'(wb_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    check("t2_stall_count", 32'(count), 32'd4);
    check("t2_hold_noWr", 32'(rf_wr_en), 32'd0);
    rf_hold = 1'b0;
    step();
    expect_wr("t2_w0", 3'd1, 16'h1001);
    check("t2_ready_back", 32'(wb_ready), 32'd1);
    check("t2_count3", 32'(count), 32'd3);
    step();
    expect_wr("t2_w1", 3'd2, 16'h2002);
    step();
    expect_wr("t2_w2", 3'd4, 16'h4004);
    step();
    expect_wr("t2_w3", 3'd6, 16'h6006);
    check("t2_count0", 32'(count), 32'd0);
    step();
    check("t2_wr_off", 32'(rf_wr_en), 32'd0);

    // same register twice: lookup returns the youngest
    rf_hold = 1'b1;
    push(3'd5, 16'h1111);
    push(3'd5, 16'h2222);
    lookup("t3_look5", 3'd5, 1'b1, 16'h2222);
`ifdef WB_COALESCE_EN
    check("t3_coal_count", 32'(count), 32'd1);
    rf_hold = 1'b0;
    step();
    expect_wr("t3_coal_w", 3'd5, 16'h2222);
    step();
    check("t3_coal_single", 32'(rf_wr_en), 32'd0);
`else
    check("t3_count", 32'(count), 32'd2);
    rf_hold = 1'b0;
    step();
    expect_wr("t3_w0", 3'd5, 16'h1111);
    step();
    expect_wr("t3_w1", 3'd5, 16'h2222);
    step();
    check("t3_wr_off", 32'(rf_wr_en), 32'd0);
`endif

    // forwarding from the output stage after the queue empties
    q_reg = 3'd2;
    push(3'd2, 16'h0042);
    lookup("t4_queued", 3'd2, 1'b1, 16'h0042);
    step();
    check("t4_empty", 32'(count), 32'd0);
    lookup("t4_outstage", 3'd2, 1'b1, 16'h0042);
    lookup("t4_other", 3'd3, 1'b0, 16'h0000);
    q_reg = 3'd2;
    step();
    lookup("t4_gone", 3'd2, 1'b0, 16'h0000);

    // queued entry is younger than the output stage and wins
    push(3'd2, 16'h000A);
    push(3'd2, 16'h000B);
    check("t4b_count", 32'(count), 32'd1);
    expect_wr("t4b_w0", 3'd2, 16'h000A);
    lookup("t4b_young", 3'd2, 1'b1, 16'h000B);
    step();
    expect_wr("t4b_w1", 3'd2, 16'h000B);
    step();

    // asynchronous reset mid-stream
    rf_hold = 1'b1;
    push(3'd1, 16'hA001);
    push(3'd2, 16'hA002);
    push(3'd3, 16'hA003);
    push(3'd4, 16'hA004);
    rf_hold = 1'b0;
    step();
    check("t5_pre_count", 32'(count), 32'd3);
    check("t5_pre_wr", 32'(rf_wr_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_wr", 32'(rf_wr_en), 32'd0);
    check("t5_rst_reg", 32'(rf_write_reg), 32'd0);
    check("t5_rst_data", 32'(rf_write_data), 32'd0);
    check("t5_rst_ready", 32'(wb_ready), 32'd1);
    lookup("t5_rst_look", 3'd2, 1'b0, 16'h0000);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_post_wr", 32'(rf_wr_en), 32'd0);
      check("t5_post_count", 32'(count), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
